// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue stage: request codes, slice control codes,
// compare selects and the decoded-entry types held in the issue buffer.
package alu_defs_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_LT   = 4'd6;
  localparam logic [3:0] OP_GT   = 4'd7;
  localparam logic [3:0] OP_LE   = 4'd8;
  localparam logic [3:0] OP_GE   = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_NE   = 4'd11;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;
  localparam logic [3:0] CTRL_CMP  = 4'b0111;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b110;
  localparam logic [2:0] CMP_NE = 3'b100;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [2:0] bonus;
    logic       cin;
  } alu_ctrl_t;

  // Decoded entry at the default array width.
  typedef struct packed {
    alu_ctrl_t              c;
    logic [ALU_WIDTH-1:0]   a;
    logic [ALU_WIDTH-1:0]   b;
  } alu_entry_t;

  // Buffer occupancy doubles as the stage state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of a request code into slice controls.
// Codes 12-15 report legal=0 with all-zero controls.
module alu_op_decode
  import alu_defs_pkg::*;
(
  input  logic [3:0] op_i,
  output alu_ctrl_t  ctrl_o,
  output logic       legal_o
);

  always_comb begin
    ctrl_o  = '0;
    legal_o = 1'b1;
    case (op_i)
      OP_AND:  ctrl_o = '{ctrl: CTRL_AND,  bonus: 3'b000, cin: 1'b0};
      OP_OR:   ctrl_o = '{ctrl: CTRL_OR,   bonus: 3'b000, cin: 1'b0};
      OP_ADD:  ctrl_o = '{ctrl: CTRL_ADD,  bonus: 3'b000, cin: 1'b0};
      OP_SUB:  ctrl_o = '{ctrl: CTRL_SUB,  bonus: 3'b000, cin: 1'b1};
      OP_NOR:  ctrl_o = '{ctrl: CTRL_NOR,  bonus: 3'b000, cin: 1'b0};
      OP_NAND: ctrl_o = '{ctrl: CTRL_NAND, bonus: 3'b000, cin: 1'b0};
      OP_LT:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_LT, cin: 1'b1};
      OP_GT:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_GT, cin: 1'b1};
      OP_LE:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_LE, cin: 1'b1};
      OP_GE:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_GE, cin: 1'b1};
      OP_EQ:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_EQ, cin: 1'b1};
      OP_NE:   ctrl_o = '{ctrl: CTRL_CMP,  bonus: CMP_NE, cin: 1'b1};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer in front of the bit-sliced ALU array. The head entry is a
// dedicated register so the array sees stable controls, held even after the last pop.
module alu_issue_stage
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       alu_bonus,
  output logic             alu_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             illegal_op,
  output logic [15:0]      issue_cnt,
  output fifo_state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on registered occupancy; out_ready is ignored while out_valid=0.
  typedef struct packed {
    alu_ctrl_t        c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  fifo_state_t state_q;
  entry_t      head_q;
  entry_t      spare_q;
  entry_t      entry_d;
  logic        illegal_q;
  logic [15:0] issue_cnt_q;

  alu_ctrl_t   dec_ctrl;
  logic        dec_legal;
  logic        accept;
  logic        push;
  logic        issue;

  alu_op_decode u_decode (
    .op_i    (in_op),
    .ctrl_o  (dec_ctrl),
    .legal_o (dec_legal)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign push      = accept & dec_legal;
  assign issue     = out_valid & out_ready;
  assign entry_d   = '{c: dec_ctrl, a: in_a, b: in_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      spare_q     <= '0;
      illegal_q   <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      illegal_q <= accept & ~dec_legal;
      if (issue) issue_cnt_q <= issue_cnt_q + 16'd1;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_q  <= entry_d;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          // With a simultaneous pop the new entry becomes the head directly.
          if (push && issue) begin
            head_q <= entry_d;
          end else if (push) begin
            spare_q <= entry_d;
            state_q <= ST_FULL;
          end else if (issue) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (issue) begin
            head_q  <= spare_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign alu_ctrl   = head_q.c.ctrl;
  assign alu_bonus  = head_q.c.bonus;
  assign alu_cin    = head_q.c.cin;
  assign alu_a      = head_q.a;
  assign alu_b      = head_q.b;
  assign illegal_op = illegal_q;
  assign issue_cnt  = issue_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode table vectors, directed handshake sequences,
// random traffic against a queue model, and the issue counter wrap.
module tb_alu_issue_stage;
  import alu_defs_pkg::*;

  localparam int W  = 32;
  localparam int EW = 8 + 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   alu_ctrl;
  logic [2:0]   alu_bonus;
  logic         alu_cin;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         illegal_op;
  logic [15:0]  issue_cnt;
  fifo_state_t  dbg_state;

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus), .alu_cin(alu_cin),
    .alu_a(alu_a), .alu_b(alu_b),
    .illegal_op(illegal_op), .issue_cnt(issue_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ctrl;
    logic [2:0] bonus;
    logic       cin;
    logic       legal;
  } vec_t;

  vec_t vecs[16];

  // Model: queue of decoded entries in accept order, issue count, last head shown.
  logic [EW-1:0] exp_q[$];
  int            m_cnt;
  logic          m_ill;
  logic [EW-1:0] m_last;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] dec_entry(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    return {vecs[op].ctrl, vecs[op].bonus, vecs[op].cin, a, b};
  endfunction

  function automatic logic [EW-1:0] dut_head();
    return {alu_ctrl, alu_bonus, alu_cin, alu_a, alu_b};
  endfunction

  task automatic tick();
    int   sz;
    logic acc, iss, lg;
    sz  = exp_q.size();
    acc = in_valid && (sz < 2);
    iss = (sz > 0) && out_ready;
    lg  = vecs[in_op].legal;
    if (!rst && iss) chk("issue_order", dut_head(), exp_q[0]);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ill  = 1'b0;
      m_last = '0;
    end else begin
      if (iss) begin
        void'(exp_q.pop_front());
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (acc && lg) exp_q.push_back(dec_entry(in_op, in_a, in_b));
      m_ill = acc && !lg;
      if (exp_q.size() > 0) m_last = exp_q[0];
    end
    #1;
    chk("in_ready",   EW'(in_ready),   EW'(exp_q.size() < 2));
    chk("out_valid",  EW'(out_valid),  EW'(exp_q.size() > 0));
    chk("illegal_op", EW'(illegal_op), EW'(m_ill));
    chk("issue_cnt",  EW'(issue_cnt),  EW'(m_cnt));
    chk("alu_fields", dut_head(),      m_last);
    chk("state",      EW'(dbg_state),  EW'(exp_q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = v;
    in_op = op;
    in_a = a;
    in_b = b;
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [2:0] bo, input logic ci,
                              input logic lg);
    vec_t v;
    v.ctrl = c; v.bonus = bo; v.cin = ci; v.legal = lg;
    return v;
  endfunction

  initial begin
    int base;
    vecs[0]  = mk(4'b0000, 3'b000, 1'b0, 1'b1);
    vecs[1]  = mk(4'b0001, 3'b000, 1'b0, 1'b1);
    vecs[2]  = mk(4'b0010, 3'b000, 1'b0, 1'b1);
    vecs[3]  = mk(4'b0110, 3'b000, 1'b1, 1'b1);
    vecs[4]  = mk(4'b1100, 3'b000, 1'b0, 1'b1);
    vecs[5]  = mk(4'b1101, 3'b000, 1'b0, 1'b1);
    vecs[6]  = mk(4'b0111, 3'b000, 1'b1, 1'b1);
    vecs[7]  = mk(4'b0111, 3'b001, 1'b1, 1'b1);
    vecs[8]  = mk(4'b0111, 3'b010, 1'b1, 1'b1);
    vecs[9]  = mk(4'b0111, 3'b011, 1'b1, 1'b1);
    vecs[10] = mk(4'b0111, 3'b110, 1'b1, 1'b1);
    vecs[11] = mk(4'b0111, 3'b100, 1'b1, 1'b1);
    for (int i = 12; i < 16; i++) vecs[i] = mk(4'b0000, 3'b000, 1'b0, 1'b0);

    drive(1'b0, 4'd0, '0, '0);
    do_reset();
    chk("reset_out_valid", EW'(out_valid), EW'(0));
    chk("reset_in_ready",  EW'(in_ready),  EW'(1));
    chk("reset_alu",       dut_head(),     '0);

    // Basic ADD: visible the cycle after accept, counted after the issue.
    out_ready = 1'b1;
    drive(1'b1, 4'd2, 32'd5, 32'd3);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("add_valid", EW'(out_valid), EW'(1));
    chk("add_head",  dut_head(), {4'b0010, 3'b000, 1'b0, 32'd5, 32'd3});
    tick();
    chk("add_cnt", EW'(issue_cnt), EW'(1));
    out_ready = 1'b0;

    // Whole decode table, one op at a time.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      if (i == 10) begin a = 32'd7; b = 32'd7; end
      drive(1'b1, 4'(i), a, b);
      tick();
      drive(1'b0, 4'd0, '0, '0);
      if (vecs[i].legal) begin
        chk($sformatf("vec%0d_valid", i), EW'(out_valid), EW'(1));
        chk($sformatf("vec%0d_head", i), dut_head(),
            {vecs[i].ctrl, vecs[i].bonus, vecs[i].cin, a, b});
      end else begin
        chk($sformatf("vec%0d_ill", i), EW'({illegal_op, out_valid}), EW'(2'b10));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Back-pressure: two accepts fill the buffer, the third waits for an issue.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k + 6), 32'(100 + k), 32'(200 + k));
      tick();
      if (k == 1) chk("full_in_ready", EW'(in_ready), EW'(0));
    end
    for (int k = 0; k < 3; k++) tick();
    chk("stall_head", dut_head(), dec_entry(4'd6, 32'd100, 32'd200));
    out_ready = 1'b1;
    tick();
    chk("full_pop_no_accept", EW'(dbg_state), EW'(ST_ONE));
    tick();
    drive(1'b0, 4'd0, '0, '0);
    for (int k = 0; k < 3; k++) tick();
    out_ready = 1'b0;

    // Count held at one with accept and issue every cycle.
    drive(1'b1, 4'd3, 32'd1, 32'd2);
    tick();
    base = m_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'($urandom_range(0, 11)), $urandom, $urandom);
      tick();
      chk("steady_one", EW'(dbg_state), EW'(ST_ONE));
    end
    chk("steady_issues", EW'(issue_cnt), EW'((base + 8) % 65536));
    drive(1'b0, 4'd0, '0, '0);
    tick();
    out_ready = 1'b0;

    // Illegal code: one-cycle pulse, nothing buffered.
    base = m_cnt;
    drive(1'b1, 4'd13, 32'd9, 32'd9);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("ill_pulse", EW'({illegal_op, out_valid}), EW'(2'b10));
    tick();
    chk("ill_clear", EW'(illegal_op), EW'(0));
    chk("ill_cnt", EW'(issue_cnt), EW'(base));

    // Reset with a full buffer.
    drive(1'b1, 4'd1, 32'd11, 32'd12);
    tick();
    tick();
    chk("prereset_full", EW'(dbg_state), EW'(ST_FULL));
    do_reset();
    chk("rst_mid", EW'({out_valid, in_ready, illegal_op, issue_cnt}), EW'({1'b0, 1'b1, 1'b0, 16'd0}));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drive(1'b0, 4'd0, '0, '0);
    out_ready = 1'b1;
    tick();
    tick();

    // Counter wrap: 65535 issues reach FFFF, one more wraps to 0.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 4'd2, $urandom, $urandom);
    for (int k = 0; k < 65536; k++) begin
      tick();
      drive(1'b1, 4'($urandom_range(0, 11)), $urandom, $urandom);
    end
    chk("cnt_ffff", EW'(issue_cnt), EW'(16'hFFFF));
    tick();
    chk("cnt_wrap", EW'(issue_cnt), EW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
